// File: rtl/bram_stepper.sv
// bram_stepper: steps an address through a small block RAM using two
// debounced pushbuttons and shows the addressed word on the LEDs.
//
// Ports:
//   clk_50   in   1       single clock, rising edge
//   reset_n  in   1       synchronous active-low reset
//   key      in   2       pushbuttons, active-low; [0] = step up, [1] = step down
//   wr_mode  in   1       1 = an up step first writes sw to the current word
//   sw       in   DATA_W  write data
//   led      out  DATA_W  registered word at the current address
//   addr     out  ADDR_W  registered current address
//   wr_ack   out  1       one-cycle pulse after a committed write

// Per-key front end: 2-flop synchroniser, level debouncer and press detector.
// press is a registered one-cycle pulse on a debounced 1->0 transition.
module bram_stepper_key #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic key,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync;   // sync[1] is the synchronised level
  logic             db;     // debounced level
  logic             db_d;   // debounced level, one cycle late
  logic [CNT_W-1:0] cnt;    // consecutive cycles sync[1] != db

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      db    <= 1'b1;
      db_d  <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      db_d  <= db;
      // only the falling debounced edge is an event; releases are ignored
      press <= db_d & ~db;
      if (sync[1] != db) begin
        // this cycle is the DEBOUNCE_CYCLES-th differing one: accept the level
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db  <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module bram_stepper #(
  parameter int DATA_W          = 4,
  parameter int ADDR_W          = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic [1:0]        key,
  input  logic              wr_mode,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] led,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_ack
);
  localparam int NUM_KEYS = 2;
  localparam int DEPTH    = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // step command decoded from the press events of one cycle
  typedef struct packed {
    logic              up;
    logic              dn;
    logic              we;
    logic [DATA_W-1:0] data;
  } step_t;

  // power-up contents: word i holds i truncated to DATA_W bits
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  logic [NUM_KEYS-1:0] press;
  step_t               cmd;
  mem_t                mem = mem_init();

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      bram_stepper_key #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk_50 (clk_50),
        .reset_n(reset_n),
        .key    (key[i]),
        .press  (press[i])
      );
    end
  endgenerate

  // simultaneous up and down cancel each other completely
  always_comb begin
    cmd      = '0;
    cmd.up   = press[0] & ~press[1];
    cmd.dn   = press[1] & ~press[0];
    cmd.we   = cmd.up & wr_mode;
    cmd.data = sw;
  end

  // array has no reset so it maps onto block RAM; a write landing on a
  // reset cycle is suppressed
  always_ff @(posedge clk_50) begin
    if (cmd.we && reset_n) mem[addr] <= cmd.data;
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      addr   <= '0;
      led    <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= cmd.we;
      // write and read share addr, so write-first simply forwards the data
      led    <= cmd.we ? cmd.data : mem[addr];
      if (cmd.up)      addr <= addr + 1'b1;
      else if (cmd.dn) addr <= addr - 1'b1;
    end
  end
endmodule

// File: doc/bram_stepper.md
BRAM_STEPPER -- requirements
Module: bram_stepper

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the memory word width and the led width.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; depth = 2^ADDR_W words.
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the consecutive stable cycles needed to accept a key level (>=2).
REQ-004 clk_50  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 key  input  2  SHALL be the pushbuttons, active-low (0 = pressed); key[0] = step-up, key[1] = step-down.
REQ-007 wr_mode  input  1  SHALL select write mode when 1, read mode when 0; sampled with the press event.
REQ-008 sw  input  DATA_W  SHALL carry the write data; sampled with the press event.
REQ-009 led  output  DATA_W  SHALL show the word at the current address, registered.
REQ-010 addr  output  ADDR_W  SHALL show the current address, registered.
REQ-011 wr_ack  output  1  SHALL pulse high for one cycle when a write is committed.

Function
REQ-012 Each key bit SHALL pass through a 2-flop synchroniser; the flops reset to 1.
REQ-013 Each synchronised key SHALL have its own debounce counter and debounced state. The state SHALL change only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the current state SHALL clear the counter.
REQ-014 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; release (0->1) SHALL produce no event.
REQ-015 A key held indefinitely SHALL produce exactly one event (no auto-repeat).
REQ-016 For an up event alone in cycle t, with wr_mode=0: addr <= addr+1 at the edge ending t, wrapping from 2^ADDR_W-1 to 0.
REQ-017 For an up event alone in cycle t, with wr_mode=1: mem[addr] <= sw and addr <= addr+1 (wrapping), both at the edge ending t; wr_ack = 1 during t+1.
REQ-018 For a down event alone, addr SHALL become addr-1, wrapping from 0 to 2^ADDR_W-1; no write occurs in either mode.
REQ-019 When up and down events occur in the same cycle, both SHALL be discarded: no address change, no write, no wr_ack.
REQ-020 led SHALL be updated every cycle with mem[addr] (synchronous read, 1-cycle latency). After an event in cycle t, led shows mem[new addr] from cycle t+2.
REQ-021 A write and a read to the same word in the same cycle SHALL return the new data (write-first).
REQ-022 The memory SHALL be inferable as block RAM: one write port, one read port, no reset on the array.
REQ-023 At configuration, mem[i] SHALL hold i mod 2^DATA_W; reset SHALL NOT alter memory contents.
REQ-024 Event to address latency SHALL be exactly 1 cycle. Key edge to event latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-025 While reset_n = 0 at a clock edge, the block SHALL set: addr = 0, led = 0, wr_ack = 0, synchronisers = 1, debounced states = 1, counters = 0. Any pending event SHALL be dropped.
REQ-026 A reset asserted mid-debounce or mid-write SHALL take precedence. A write whose event cycle coincides with a reset cycle SHALL NOT occur.
REQ-027 On the first cycle after reset release, led SHALL read mem[0].

Verification (DEBOUNCE_CYCLES = 4, DATA_W = 4, ADDR_W = 4)
REQ-028 Reset, then key[0] low for 10 cycles with wr_mode=0: exactly one event; addr 0->1; led = 1 two cycles after the event.
REQ-029 key[0] toggling every 2 cycles for 20 cycles (bounce): no event; addr unchanged. Then held low: exactly one event.
REQ-030 Sequence: addr=15, up event -> addr = 0, led = 0. Then a down event -> addr = 15, led = 15.
REQ-031 At addr=3, wr_mode=1, sw=4'hA, up event: wr_ack pulses once; addr = 4. Then a down event: led = 4'hA. A reset afterwards leaves mem[3] = 4'hA.
REQ-032 Both keys pressed with identical timing: the simultaneous events produce no addr change, no write, and wr_ack stays 0.
REQ-033 With key[0] debounce counter at 3 of 4, assert reset_n = 0 for one cycle: addr = 0, and no event afterwards until a full new 4-cycle stable low.
